// File: rtl/seq_addsub_cla.sv
// -----------------------------------------------------------------------------
// seq_addsub_cla
//   Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair is
//   resolved CHUNK bits per clock by a single carry-lookahead slice. The carry
//   between chunks is held in a register, so one operation takes
//   N = WIDTH/CHUNK RUN cycles.
//
//   Add      : sum = a + b + cin
//   Subtract : sum = a + ~b + ~cin  (= a - b - cin); cout = 1 means no borrow
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous, active-high reset (priority over everything)
//   i_in_valid   operands and mode valid
//   o_in_ready   block can accept an operation (IDLE)
//   i_a, i_b     WIDTH-bit operands
//   i_cin        carry-in (add) / borrow-in (subtract)
//   i_sub        0: add, 1: subtract
//   o_out_valid  result valid (DONE)
//   i_out_ready  consumer accepts the result
//   o_sum        WIDTH-bit result (partial during RUN, valid only in DONE)
//   o_cout       carry out of bit WIDTH-1
//   o_ovf        signed overflow (carry into MSB XOR carry out of MSB)
//   o_zero       final sum is zero
// -----------------------------------------------------------------------------
module seq_addsub_cla #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int N  = WIDTH / CHUNK;
  // Counter is at least one bit wide so that the N = 1 case still elaborates.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST_CNT   = CW'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reject operand widths that do not split into whole chunks.
  if (WIDTH % CHUNK != 0) begin : g_bad_params
    $error("seq_addsub_cla: WIDTH must be an integer multiple of CHUNK");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already inverted for subtract
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_slice_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  // Shift-based chunk selection keeps the index arithmetic width-clean.
  assign w_base    = 32'(r_cnt) * 32'(CHUNK);
  assign w_a_chunk = CHUNK'(r_a >> w_base);
  assign w_b_chunk = CHUNK'(r_b >> w_base);
  assign w_last    = (r_cnt == LAST_CNT);

  // Carry-lookahead slice: every carry is formed directly from g/p terms and
  // the incoming chunk carry, not rippled bit to bit.
  always_comb begin : p_cla
    logic v_acc;
    logic v_prod;
    w_g    = w_a_chunk & w_b_chunk;
    w_p    = w_a_chunk ^ w_b_chunk;
    w_c    = {(CHUNK + 1){1'b0}};
    w_c[0] = r_carry;
    v_acc  = 1'b0;
    v_prod = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      v_acc  = w_g[i];
      v_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        v_acc  = v_acc | (v_prod & w_g[j]);
        v_prod = v_prod & w_p[j];
      end
      w_c[i+1] = v_acc | (v_prod & r_carry);
    end
    w_slice_sum = w_p ^ w_c[CHUNK-1:0];
  end

  // Merge the freshly computed chunk into the running sum.
  always_comb begin
    w_sum_next = (r_sum & ~(CHUNK_MASK << w_base)) |
                 (WIDTH'(w_slice_sum) << w_base);
  end

  // Control FSM plus datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_sum       <= {WIDTH{1'b0}};
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_a;
            r_b        <= i_sub ? ~i_b : i_b;
            r_carry    <= i_sub ? ~i_cin : i_cin;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c[CHUNK];
          if (w_last) begin
            // The last slice holds the MSB, so its carries give the flags.
            r_cout      <= w_c[CHUNK];
            r_ovf       <= w_c[CHUNK] ^ w_c[CHUNK-1];
            r_zero      <= (w_sum_next == {WIDTH{1'b0}});
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt       <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_seq_addsub_cla.sv
// -----------------------------------------------------------------------------
// tb_seq_addsub_cla
//   Directed-vector bench for seq_addsub_cla (WIDTH=16, CHUNK=4, N=4).
//   An arithmetic reference model predicts each result; hand-computed values
//   pin that model. One compare task runs every cycle, checking handshake
//   outputs against the expected protocol timing and the result against the
//   model whenever out_valid should be high.
// -----------------------------------------------------------------------------
module tb_seq_addsub_cla;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  seq_addsub_cla #(.WIDTH(W), .CHUNK(C)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .i_sub       (sub),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout),
    .o_ovf       (ovf),
    .o_zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t exp_q[$];
  res_t lit_res;
  bit   lit_valid = 1'b0;
  int   n_chk     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   acc_cyc   = 0;
  bit   busy      = 1'b0;
  bit   armed     = 1'b0;
  bit   post_rst  = 1'b0;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fci, input logic fsb);
    res_t   r;
    longint ua, ub, sa, sbv, ci, raw, sraw;
    ua  = longint'(fa);
    ub  = longint'(fb);
    sa  = longint'($signed(fa));
    sbv = longint'($signed(fb));
    ci  = longint'(fci);
    if (!fsb) begin
      raw    = ua + ub + ci;
      sraw   = sa + sbv + ci;
      r.cout = (raw >= (longint'(1) <<< W));
    end else begin
      raw    = ua - ub - ci;
      sraw   = sa - sbv - ci;
      r.cout = (ua >= ub + ci);
    end
    r.sum  = raw[W-1:0];
    r.ovf  = (sraw > ((longint'(1) <<< (W - 1)) - 1)) ||
             (sraw < -(longint'(1) <<< (W - 1)));
    r.zero = (r.sum == {W{1'b0}});
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the edge.
  task automatic cmp();
    bit   exp_ov;
    res_t r;
    exp_ov = busy && (cyc >= acc_cyc + N + 1);
    if (armed) begin
      if (post_rst) begin
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        post_rst = 1'b0;
      end
      chk("in_ready",  32'(in_ready),  32'(!busy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && out_valid && exp_q.size() > 0) begin
        chk("sum",  32'(sum),  32'(exp_q[0].sum));
        chk("cout", 32'(cout), 32'(exp_q[0].cout));
        chk("ovf",  32'(ovf),  32'(exp_q[0].ovf));
        chk("zero", 32'(zero), 32'(exp_q[0].zero));
      end
    end
    if (rst) begin
      busy     = 1'b0;
      exp_q.delete();
      armed    = 1'b1;
      post_rst = 1'b1;
    end else if (!busy) begin
      if (in_valid && armed) begin
        busy    = 1'b1;
        acc_cyc = cyc;
        r       = model(a, b, cin, sub);
        if (lit_valid) begin
          chk("model_sum",  32'(r.sum),  32'(lit_res.sum));
          chk("model_cout", 32'(r.cout), 32'(lit_res.cout));
          chk("model_ovf",  32'(r.ovf),  32'(lit_res.ovf));
          chk("model_zero", 32'(r.zero), 32'(lit_res.zero));
        end
        exp_q.push_back(r);
      end
    end else if (exp_ov && out_ready) begin
      busy = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_in(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsb,
                        input logic [W-1:0] ls, input logic lc,
                        input logic lo, input logic lz);
    a            = ta;
    b            = tb;
    cin          = tci;
    sub          = tsb;
    lit_res.sum  = ls;
    lit_res.cout = lc;
    lit_res.ovf  = lo;
    lit_res.zero = lz;
    lit_valid    = 1'b1;
    in_valid     = 1'b1;
  endtask

  // Operands are scrambled after capture; the result must not depend on them.
  task automatic clr_in();
    in_valid  = 1'b0;
    lit_valid = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    cin       = 1'($urandom);
    sub       = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && !out_valid; k++) begin
      in_valid = (k == 1);
      step();
    end
    in_valid = 1'b0;
    chk("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic hold_done(input int h);
    for (int i = 0; i < h; i++) begin
      in_valid = i[0];
      a        = W'($urandom);
      b        = W'($urandom);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tci, input logic tsb,
                       input logic [W-1:0] ls, input logic lc,
                       input logic lo, input logic lz, input int h);
    set_in(ta, tb, tci, tsb, ls, lc, lo, lz);
    step();
    clr_in();
    wait_done();
    hold_done(h);
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = {W{1'b0}};
    b         = {W{1'b0}};
    cin       = 1'b0;
    sub       = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
    do_op(16'h8000, 16'h8001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 0);
    do_op(16'h4000, 16'h0005, 1'b0, 1'b1, 16'h3FFB, 1'b1, 1'b0, 1'b0, 0);
    do_op(16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 0);
    do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 5);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    do_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);

    // New request presented on the drain edge: accepted one cycle later.
    set_in(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    step();
    clr_in();
    wait_done();
    set_in(16'h0003, 16'h0002, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    clr_in();
    wait_done();
    drain();

    // Reset during RUN: operation aborted, no result pulse afterwards.
    set_in(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    clr_in();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
    end

    do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0, 1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_addsub_cla.md
Name: seq_addsub_cla

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Walks a WIDTH-bit operand pair through one CHUNK-bit carry-lookahead slice per clock, rippling the carry through a register between chunks.
- Trades latency for area in wide datapaths.
- Sits behind a valid/ready input port and a valid/ready output port, with flags for carry, signed overflow and zero.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits resolved per cycle by the internal CLA slice; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB (subtract: 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset: synchronous, active-high, takes priority over all other inputs.
  - state = IDLE, chunk counter = 0, carry register = 0, operand registers = 0.
  - sum = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready = 1 in the first cycle after reset.
- Arithmetic:
  - add: sum = a + b + cin.
  - subtract: sum = a + ~b + ~cin, i.e. a - b - cin.
  - Inversion of b is applied at capture.
  - Initial carry register = sub ? ~cin : cin.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero computed on the final sum.
- States IDLE, RUN, DONE:
  - IDLE: in_ready = 1, out_valid = 0.
    - On an edge with in_valid = 1: capture a, b (inverted if sub), initial carry; counter = 0; go to RUN.
    - Otherwise hold.
  - RUN: in_ready = 0, out_valid = 0.
    - Each edge: CLA slice adds chunk[counter] of both operands plus the carry register.
    - Writes sum bits [counter*CHUNK +: CHUNK], updates the carry register, counter increments.
    - On the edge where counter == N-1: record cout and ovf from the MSB slice; go to DONE.
    - in_valid is ignored while in RUN.
  - DONE: out_valid = 1, in_ready = 0.
    - sum and flags held stable until out_ready = 1.
    - On an edge with out_ready = 1: go to IDLE; out_valid deasserts next cycle.
- Latency: out_valid rises exactly N cycles after the accepting edge (N = 8 with defaults).
  - Throughput: one operation per N+2 cycles minimum.
  - No same-cycle result-drain/new-accept.
- sum, cout, ovf and zero are valid only while out_valid = 1.
  - sum holds a partial result during RUN and must not be sampled.
- Input operands may change freely after the accepting edge; the result depends only on captured values.
- rst asserted mid-RUN or in DONE: the operation is aborted, the result is discarded, reset values are applied on that edge, and no out_valid pulse occurs.
- The CHUNK = WIDTH degenerate case (N = 1) must work: one RUN cycle.
- Illegal parameter combination (WIDTH % CHUNK != 0) is rejected at elaboration.

Test Plan:
- All cases use WIDTH=16, CHUNK=4 (N=4).
- Add: a=0x0001, b=0x0001, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x0002, cout=0, ovf=0, zero=0.
- Add overflow: a=0x8000, b=0x8001, cin=0, sub=0 -> sum=0x0001, cout=1, ovf=1, zero=0.
- Subtract: a=0x4000, b=0x0005, cin=0, sub=1 -> sum=0x3FFB, cout=1, ovf=0.
- Subtract, signed overflow plus zero check:
  - a=0x8000, b=0x7FFF, sub=1, cin=0 -> sum=0x0001, cout=1, ovf=1.
  - Then a=0x1234, b=0x1234, sub=1, cin=0 -> sum=0x0000, zero=1, cout=1.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/flags stable, in_ready=0.
  - Pulse in_valid with new operands during RUN and DONE -> ignored.
  - Raise out_ready -> IDLE next cycle, then the next operation is accepted.
- Reset mid-op: accept a=0xFFFF, b=0x0001, assert rst at RUN cycle 2 -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1, and no result pulse ever appears.
